// File: rtl/ans_rans_encoder.sv
// rtl/ans_rans_encoder.sv - streaming rANS encoder with loadable frequency table
// Sequential restoring divider per symbol; renorm words and flush words share one output stream.
module ans_rans_encoder #(
  parameter int SYM_WIDTH   = 4,
  parameter int PROB_BITS   = 8,
  parameter int STATE_WIDTH = 16,
  parameter int OUT_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cmd,
  input  logic [PROB_BITS-1:0]   in_data,
  input  logic                   in_vld,
  output logic                   in_rdy,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   out_last,
  output logic                   cfg_err,
  output logic                   sym_err,
  output logic                   busy
);

  localparam int N     = 1 << SYM_WIDTH;
  localparam int WORDS = STATE_WIDTH / OUT_WIDTH;
  localparam int CW    = $clog2(STATE_WIDTH + 1);
  localparam logic [STATE_WIDTH-1:0] X_INIT = STATE_WIDTH'(1) << (STATE_WIDTH - OUT_WIDTH);
  localparam logic [PROB_BITS:0]     M_VAL  = (PROB_BITS+1)'(1) << PROB_BITS;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RENORM, S_DIV, S_UPDATE, S_FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [STATE_WIDTH-1:0] x_q;
  logic [PROB_BITS-1:0]   freq_q [N];
  logic [PROB_BITS:0]     cum_q  [N];
  logic [PROB_BITS:0]     sum_q;
  logic                   sum_ovf_q;
  logic [SYM_WIDTH-1:0]   idx_q;
  logic                   table_ok_q, cfg_err_q, sym_err_q;
  logic [PROB_BITS-1:0]   f_q;
  logic [PROB_BITS:0]     c_q;
  logic [PROB_BITS:0]     rem_q;
  logic [STATE_WIDTH-1:0] quo_q;
  logic [CW-1:0]          cnt_q;

  logic [SYM_WIDTH-1:0]   sym;
  logic                   in_hs, out_hs, renorm_emit, div_ge;
  logic [STATE_WIDTH-1:0] x_max, upd_x;
  logic [PROB_BITS+1:0]   sum_ext, trial;
  logic [PROB_BITS:0]     diff;

  assign sym         = in_data[SYM_WIDTH-1:0];
  assign in_hs       = in_vld && in_rdy;
  assign out_hs      = out_vld && out_rdy;
  // x_max = ((L >> PROB_BITS) << OUT_WIDTH) * f collapses to f << (STATE_WIDTH - PROB_BITS)
  assign x_max       = {f_q, {(STATE_WIDTH-PROB_BITS){1'b0}}};
  assign renorm_emit = (x_q >= x_max);
  assign sum_ext     = {1'b0, sum_q} + {2'b00, in_data};
  assign trial       = {rem_q, quo_q[STATE_WIDTH-1]};
  assign div_ge      = (trial >= {2'b00, f_q});
  assign diff        = trial[PROB_BITS:0] - {1'b0, f_q};
  assign upd_x       = (quo_q << PROB_BITS) + STATE_WIDTH'(rem_q) + STATE_WIDTH'(c_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd == 2'b11 && in_hs)                              state_d = S_LOAD;
        else if (cmd == 2'b01 && in_hs && freq_q[sym] != '0)    state_d = S_RENORM;
        else if (cmd == 2'b10)                                  state_d = S_FLUSH;
      end
      S_LOAD:   if (in_hs && idx_q == SYM_WIDTH'(N-1)) state_d = S_IDLE;
      S_RENORM: if (!renorm_emit) state_d = S_DIV;
      S_DIV:    if (cnt_q == CW'(STATE_WIDTH-1)) state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      S_FLUSH:  if (out_hs && cnt_q == CW'(WORDS-1)) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    out_data = '0;
    out_last = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:   in_rdy = (cmd == 2'b11) || (cmd == 2'b01 && table_ok_q);
      S_LOAD:   in_rdy = 1'b1;
      S_RENORM: begin
        out_vld  = renorm_emit;
        out_data = renorm_emit ? x_q[OUT_WIDTH-1:0] : '0;
      end
      S_FLUSH: begin
        out_vld  = 1'b1;
        out_data = x_q[OUT_WIDTH-1:0];
        out_last = (cnt_q == CW'(WORDS-1));
      end
      default: ;
    endcase
  end

  assign cfg_err = cfg_err_q;
  assign sym_err = sym_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= X_INIT;
      sum_q      <= '0;
      sum_ovf_q  <= 1'b0;
      idx_q      <= '0;
      table_ok_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      sym_err_q  <= 1'b0;
      f_q        <= '0;
      c_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < N; i++) begin
        freq_q[i] <= '0;
        cum_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd == 2'b11 && in_hs) begin
            freq_q[0]  <= in_data;
            cum_q[0]   <= '0;
            sum_q      <= {1'b0, in_data};
            sum_ovf_q  <= 1'b0;
            idx_q      <= SYM_WIDTH'(1);
            table_ok_q <= 1'b0;
            sym_err_q  <= 1'b0;
          end else if (cmd == 2'b01 && in_hs) begin
            if (freq_q[sym] == '0) begin
              sym_err_q <= 1'b1;
            end else begin
              f_q <= freq_q[sym];
              c_q <= cum_q[sym];
            end
          end
          cnt_q <= '0;
        end
        S_LOAD: if (in_hs) begin
          freq_q[idx_q] <= in_data;
          cum_q[idx_q]  <= sum_q;
          sum_q         <= sum_ext[PROB_BITS:0];
          sum_ovf_q     <= sum_ovf_q | sum_ext[PROB_BITS+1];
          idx_q         <= idx_q + SYM_WIDTH'(1);
          if (idx_q == SYM_WIDTH'(N-1)) begin
            // A wrapped running sum must never alias to a valid total
            table_ok_q <= !sum_ovf_q && !sum_ext[PROB_BITS+1] && (sum_ext[PROB_BITS:0] == M_VAL);
            cfg_err_q  <= !(!sum_ovf_q && !sum_ext[PROB_BITS+1] && (sum_ext[PROB_BITS:0] == M_VAL));
            x_q        <= X_INIT;
          end
        end
        S_RENORM: begin
          if (renorm_emit) begin
            if (out_rdy) x_q <= x_q >> OUT_WIDTH;
          end else begin
            rem_q <= '0;
            quo_q <= x_q;
            cnt_q <= '0;
          end
        end
        S_DIV: begin
          rem_q <= div_ge ? diff : trial[PROB_BITS:0];
          quo_q <= {quo_q[STATE_WIDTH-2:0], div_ge};
          cnt_q <= cnt_q + CW'(1);
        end
        S_UPDATE: x_q <= upd_x;
        S_FLUSH: if (out_hs) begin
          if (cnt_q == CW'(WORDS-1)) begin
            x_q   <= X_INIT;
            cnt_q <= '0;
          end else begin
            x_q   <= x_q >> OUT_WIDTH;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_rans_encoder.sv
// tb/tb_ans_rans_encoder.sv - directed table-driven bench for ans_rans_encoder
// Expected words/states are hand-derived for the default parameters (L=4096, M=256).
module tb_ans_rans_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd;
  logic [7:0] in_data;
  logic       in_vld;
  logic       in_rdy;
  logic [3:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       out_last;
  logic       cfg_err;
  logic       sym_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ft [16];

  typedef struct {
    logic [3:0]  sym;
    int          nw;
    logic [3:0]  w0;
    logic [3:0]  w1;
    logic [15:0] x;
  } vec_t;

  vec_t vt [6];

  ans_rans_encoder dut (
    .clk(clk), .rst(rst), .cmd(cmd), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .cfg_err(cfg_err), .sym_err(sym_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_load();
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cmd = 2'b11; in_data = ft[i]; in_vld = 1'b1;
      #1;
      if (!in_rdy) bad++;
    end
    @(negedge clk);
    in_vld = 1'b0; cmd = 2'b00;
    chk("load_rdy_beats", bad, 0);
  endtask

  task automatic do_encode(input logic [3:0] sym, output int nw, output logic [3:0] w0,
                           output logic [3:0] w1, output int lat);
    int guard = 0;
    nw = 0; w0 = 4'h0; w1 = 4'h0; lat = 0;
    @(negedge clk);
    cmd = 2'b01; in_data = {4'h0, sym}; in_vld = 1'b1; out_rdy = 1'b1;
    #1;
    chk("enc_in_rdy", in_rdy, 1);
    @(negedge clk);
    in_vld = 1'b0;
    while (!in_rdy && guard < 200) begin
      if (out_vld && out_rdy) begin
        if (nw == 0) w0 = out_data;
        else if (nw == 1) w1 = out_data;
        nw++;
      end
      @(negedge clk);
      lat++; guard++;
    end
    if (guard >= 200) begin
      checks++; failures++;
      $display("FAIL enc_timeout actual=%0d required=<200", guard);
    end
    cmd = 2'b00;
  endtask

  task automatic do_flush(input logic [15:0] xexp);
    int guard = 0;
    int nw = 0;
    logic stalled = 1'b0;
    logic [3:0] prev_d = 4'h0;
    logic prev_l = 1'b0;
    logic rdy_t = 1'b0;
    @(negedge clk);
    cmd = 2'b10; in_vld = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    cmd = 2'b00;
    while (nw < 4 && guard < 60) begin
      if (stalled) begin
        chk("flush_hold_vld", out_vld, 1);
        chk("flush_hold_data", out_data, prev_d);
        chk("flush_hold_last", out_last, prev_l);
      end
      out_rdy = rdy_t;
      if (out_vld && out_rdy) begin
        chk("flush_word", out_data, xexp[4*nw +: 4]);
        chk("flush_last", out_last, (nw == 3));
        nw++;
        stalled = 1'b0;
      end else if (out_vld) begin
        stalled = 1'b1;
        prev_d  = out_data;
        prev_l  = out_last;
      end
      rdy_t = ~rdy_t;
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) begin
      checks++; failures++;
      $display("FAIL flush_timeout actual=%0d words required=4", nw);
    end
    out_rdy = 1'b1;
    chk("flush_busy_after", busy, 0);
    chk("flush_x_after", dut.x_q, 16'h1000);
  endtask

  initial begin
    int nw, lat, seen;
    logic [3:0] w0, w1;

    vt[0] = '{sym: 4'd0,  nw: 0, w0: 4'h0, w1: 4'h0, x: 16'h1E10};
    vt[1] = '{sym: 4'd1,  nw: 1, w0: 4'h0, w1: 4'h0, x: 16'h3C89};
    vt[2] = '{sym: 4'd2,  nw: 1, w0: 4'h9, w1: 4'h0, x: 16'h7990};
    vt[3] = '{sym: 4'd15, nw: 1, w0: 4'h0, w1: 4'h0, x: 16'hF3F9};
    vt[4] = '{sym: 4'd3,  nw: 2, w0: 4'h9, w1: 4'hF, x: 16'h1E9B};
    vt[5] = '{sym: 4'd0,  nw: 0, w0: 4'h0, w1: 4'h0, x: 16'h3953};

    rst = 1'b1; cmd = 2'b01; in_data = 8'h0; in_vld = 1'b0; out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_sym_err", sym_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", dut.x_q, 16'h1000);
    rst = 1'b0; cmd = 2'b00;

    // Uniform table
    for (int i = 0; i < 16; i++) ft[i] = 8'd16;
    do_load();
    chk("uni_cfg_err", cfg_err, 0);
    cmd = 2'b01; #1;
    chk("uni_in_rdy", in_rdy, 1);
    chk("uni_x", dut.x_q, 16'h1000);
    cmd = 2'b00;

    do_encode(4'd3, nw, w0, w1, lat);
    chk("enc3_nwords", nw, 1);
    chk("enc3_word", w0, 4'h0);
    chk("enc3_latency", lat, 19);
    chk("enc3_x", dut.x_q, 16'h1030);

    do_flush(16'h1030);

    // Skewed table: freq[0]=136, others 8
    ft[0] = 8'd136;
    for (int i = 1; i < 16; i++) ft[i] = 8'd8;
    do_load();
    chk("skew_cfg_err", cfg_err, 0);
    chk("skew_x", dut.x_q, 16'h1000);
    for (int v = 0; v < 6; v++) begin
      do_encode(vt[v].sym, nw, w0, w1, lat);
      chk($sformatf("vec%0d_nwords", v), nw, vt[v].nw);
      chk($sformatf("vec%0d_w0", v), w0, vt[v].w0);
      chk($sformatf("vec%0d_w1", v), w1, vt[v].w1);
      chk($sformatf("vec%0d_latency", v), lat, 18 + vt[v].nw);
      chk($sformatf("vec%0d_x", v), dut.x_q, vt[v].x);
    end
    do_flush(16'h3953);

    // Table summing to 255
    for (int i = 0; i < 15; i++) ft[i] = 8'd16;
    ft[15] = 8'd15;
    do_load();
    chk("bad_cfg_err", cfg_err, 1);
    cmd = 2'b01; #1;
    chk("bad_in_rdy", in_rdy, 0);
    cmd = 2'b00;
    ft[15] = 8'd16;
    do_load();
    chk("reload_cfg_err", cfg_err, 0);
    cmd = 2'b01; #1;
    chk("reload_in_rdy", in_rdy, 1);
    cmd = 2'b00;

    // Zero-frequency symbol 5
    ft[0] = 8'd32;
    for (int i = 1; i < 16; i++) ft[i] = 8'd16;
    ft[5] = 8'd0;
    do_load();
    chk("zf_cfg_err", cfg_err, 0);
    @(negedge clk);
    cmd = 2'b01; in_data = 8'd5; in_vld = 1'b1;
    #1;
    chk("zf_in_rdy", in_rdy, 1);
    @(negedge clk);
    in_vld = 1'b0;
    chk("zf_sym_err", sym_err, 1);
    chk("zf_busy", busy, 0);
    chk("zf_x", dut.x_q, 16'h1000);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_vld) seen++;
      @(negedge clk);
    end
    chk("zf_no_words", seen, 0);
    do_encode(4'd0, nw, w0, w1, lat);
    chk("zf_enc0_nwords", nw, 0);
    chk("zf_enc0_x", dut.x_q, 16'h8000);
    chk("zf_sym_err_sticky", sym_err, 1);

    for (int i = 0; i < 16; i++) ft[i] = 8'd16;
    do_load();
    chk("load_clears_sym_err", sym_err, 0);

    // Reset during the 8th DIV cycle
    @(negedge clk);
    cmd = 2'b01; in_data = 8'd3; in_vld = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    in_vld = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_div_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_div_busy", busy, 0);
    chk("rst_div_out_vld", out_vld, 0);
    chk("rst_div_in_rdy", in_rdy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_div_x", dut.x_q, 16'h1000);
    chk("rst_div_in_rdy_after", in_rdy, 0);
    cmd = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
